// File: rtl/timer_bcd_hms.sv
// BCD hh:mm:ss time base with a built-in prescaler, up/down counting,
// a configurable hour modulus, countdown-to-zero stop and an alarm comparator.
// All three fields advance on the same clock edge through a tick-enable
// carry chain; nothing is ripple clocked.
module timer_bcd_hms #(
    parameter int unsigned DIV          = 1,
    parameter logic [7:0]  HOUR_MAX     = 8'h23,
    parameter bit          STOP_AT_ZERO = 1'b1
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       CE,
    input  logic       UP,
    input  logic       PE,
    input  logic [7:0] D_H,
    input  logic [7:0] D_M,
    input  logic [7:0] D_S,
    input  logic       AL_EN,
    input  logic [7:0] AL_H,
    input  logic [7:0] AL_M,
    input  logic [7:0] AL_S,
    output logic [7:0] Q_H,
    output logic [7:0] Q_M,
    output logic [7:0] Q_S,
    output logic       TC_S,
    output logic       TC_M,
    output logic       TC_H,
    output logic       TICK,
    output logic       DONE,
    output logic       ALARM,
    output logic       LD_ERR
);

    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    MS_MAX     = 8'h59;

    // Both nibbles decimal and the value within the field range.
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    logic [7:0]    h_q, m_q, s_q;
    logic [7:0]    h_nxt, m_nxt, s_nxt;
    logic [PW-1:0] presc_q;
    logic          tick_q, done_q, alarm_q, ld_err_q;
    logic          presc_wrap, hold_zero, do_update, alarm_hit, ld_bad;
    logic          tc_s, tc_m, tc_h;

    // Terminal counts, carry chain and next-field values.
    always_comb begin
        presc_wrap = CE && (presc_q == PRESC_LAST);
        // Countdown parked at zero: prescaler keeps running, count does not.
        hold_zero  = STOP_AT_ZERO && !UP && ({h_q, m_q, s_q} == 24'h0);
        do_update  = presc_wrap && !hold_zero;

        tc_s = CE && (UP ? (s_q == MS_MAX)   : (s_q == 8'h00));
        tc_m = CE && (UP ? (m_q == MS_MAX)   : (m_q == 8'h00));
        tc_h = CE && (UP ? (h_q == HOUR_MAX) : (h_q == 8'h00));

        s_nxt = UP ? bcd_inc(s_q, MS_MAX) : bcd_dec(s_q, MS_MAX);
        m_nxt = m_q;
        h_nxt = h_q;
        if (tc_s) begin
            m_nxt = UP ? bcd_inc(m_q, MS_MAX) : bcd_dec(m_q, MS_MAX);
        end
        if (tc_s && tc_m) begin
            h_nxt = UP ? bcd_inc(h_q, HOUR_MAX) : bcd_dec(h_q, HOUR_MAX);
        end

        alarm_hit = AL_EN && ({h_nxt, m_nxt, s_nxt} == {AL_H, AL_M, AL_S});
        ld_bad    = !bcd_valid(D_H, HOUR_MAX) || !bcd_valid(D_M, MS_MAX) ||
                    !bcd_valid(D_S, MS_MAX);
    end

    // Counter, prescaler and status registers; reset beats load beats count.
    always_ff @(posedge CP) begin
        if (CR) begin
            h_q      <= 8'h00;
            m_q      <= 8'h00;
            s_q      <= 8'h00;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            alarm_q  <= 1'b0;
            ld_err_q <= 1'b0;
        end else if (PE) begin
            h_q      <= bcd_valid(D_H, HOUR_MAX) ? D_H : 8'h00;
            m_q      <= bcd_valid(D_M, MS_MAX)   ? D_M : 8'h00;
            s_q      <= bcd_valid(D_S, MS_MAX)   ? D_S : 8'h00;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            alarm_q  <= 1'b0;
            ld_err_q <= ld_bad;
        end else begin
            tick_q   <= presc_wrap;
            alarm_q  <= do_update && alarm_hit;
            ld_err_q <= 1'b0;
            if (CE) begin
                presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            end
            if (do_update) begin
                h_q <= h_nxt;
                m_q <= m_nxt;
                s_q <= s_nxt;
            end
            // DONE only rises through a down step landing on zero.
            if (CE && UP) begin
                done_q <= 1'b0;
            end else if (do_update && STOP_AT_ZERO && !UP &&
                         ({h_nxt, m_nxt, s_nxt} == 24'h0)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        Q_H    = h_q;
        Q_M    = m_q;
        Q_S    = s_q;
        TC_S   = tc_s;
        TC_M   = tc_m;
        TC_H   = tc_h;
        TICK   = tick_q;
        DONE   = done_q;
        ALARM  = alarm_q;
        LD_ERR = ld_err_q;
    end

endmodule

// File: tb/tb_timer_bcd_hms.sv
// Bench for timer_bcd_hms: three instances with different parameters share
// one stimulus stream; each is compared every cycle against a seconds-based
// reference model, plus a vector table and directed multi-cycle sequences.
module tb_timer_bcd_hms;

    localparam int unsigned DIV_A = 1, DIV_B = 4, DIV_C = 1;
    localparam logic [7:0]  HM_A = 8'h23, HM_B = 8'h23, HM_C = 8'h11;
    localparam bit          ST_A = 1'b1, ST_B = 1'b1, ST_C = 1'b0;

    int m_div  [3] = '{1, 4, 1};
    int m_hmax [3] = '{23, 23, 11};
    bit m_stop [3] = '{1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       cr = 1'b0, pe = 1'b0, ce = 1'b0, up = 1'b1, al_en = 1'b0;
    logic [7:0] d_h = 8'h00, d_m = 8'h00, d_s = 8'h00;
    logic [7:0] al_h = 8'h00, al_m = 8'h00, al_s = 8'h00;

    logic [2:0][7:0] q_h, q_m, q_s;
    logic [2:0]      tc_s, tc_m, tc_h, tick, done, alarm, ld_err;

    timer_bcd_hms #(.DIV(DIV_A), .HOUR_MAX(HM_A), .STOP_AT_ZERO(ST_A)) dut_a (
        .CP(clk), .CR(cr), .CE(ce), .UP(up), .PE(pe),
        .D_H(d_h), .D_M(d_m), .D_S(d_s),
        .AL_EN(al_en), .AL_H(al_h), .AL_M(al_m), .AL_S(al_s),
        .Q_H(q_h[0]), .Q_M(q_m[0]), .Q_S(q_s[0]),
        .TC_S(tc_s[0]), .TC_M(tc_m[0]), .TC_H(tc_h[0]),
        .TICK(tick[0]), .DONE(done[0]), .ALARM(alarm[0]), .LD_ERR(ld_err[0])
    );

    timer_bcd_hms #(.DIV(DIV_B), .HOUR_MAX(HM_B), .STOP_AT_ZERO(ST_B)) dut_b (
        .CP(clk), .CR(cr), .CE(ce), .UP(up), .PE(pe),
        .D_H(d_h), .D_M(d_m), .D_S(d_s),
        .AL_EN(al_en), .AL_H(al_h), .AL_M(al_m), .AL_S(al_s),
        .Q_H(q_h[1]), .Q_M(q_m[1]), .Q_S(q_s[1]),
        .TC_S(tc_s[1]), .TC_M(tc_m[1]), .TC_H(tc_h[1]),
        .TICK(tick[1]), .DONE(done[1]), .ALARM(alarm[1]), .LD_ERR(ld_err[1])
    );

    timer_bcd_hms #(.DIV(DIV_C), .HOUR_MAX(HM_C), .STOP_AT_ZERO(ST_C)) dut_c (
        .CP(clk), .CR(cr), .CE(ce), .UP(up), .PE(pe),
        .D_H(d_h), .D_M(d_m), .D_S(d_s),
        .AL_EN(al_en), .AL_H(al_h), .AL_M(al_m), .AL_S(al_s),
        .Q_H(q_h[2]), .Q_M(q_m[2]), .Q_S(q_s[2]),
        .TC_S(tc_s[2]), .TC_M(tc_m[2]), .TC_H(tc_h[2]),
        .TICK(tick[2]), .DONE(done[2]), .ALARM(alarm[2]), .LD_ERR(ld_err[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time held as a plain count of seconds.
    int m_t [3];
    int m_presc [3];
    bit m_tick [3], m_done [3], m_alarm [3], m_lderr [3];

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v, input int max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= max);
    endfunction

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit hits_alarm(input int t);
        return to_bcd(t / 3600) == al_h && to_bcd((t / 60) % 60) == al_m &&
               to_bcd(t % 60) == al_s;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int n;
            bit wrap;
            n = (m_hmax[i] + 1) * 3600;
            if (cr) begin
                m_t[i] = 0; m_presc[i] = 0; m_tick[i] = 0;
                m_done[i] = 0; m_alarm[i] = 0; m_lderr[i] = 0;
            end else if (pe) begin
                m_t[i] = (bcd_ok(d_h, m_hmax[i]) ? bcd_val(d_h) : 0) * 3600 +
                         (bcd_ok(d_m, 59) ? bcd_val(d_m) : 0) * 60 +
                         (bcd_ok(d_s, 59) ? bcd_val(d_s) : 0);
                m_presc[i] = 0; m_tick[i] = 0; m_done[i] = 0; m_alarm[i] = 0;
                m_lderr[i] = !bcd_ok(d_h, m_hmax[i]) || !bcd_ok(d_m, 59) ||
                             !bcd_ok(d_s, 59);
            end else begin
                m_tick[i] = 0; m_alarm[i] = 0; m_lderr[i] = 0;
                if (ce) begin
                    wrap = (m_presc[i] == m_div[i] - 1);
                    m_presc[i] = wrap ? 0 : m_presc[i] + 1;
                    m_tick[i] = wrap;
                    if (up) m_done[i] = 0;
                    if (wrap && !(m_stop[i] && !up && m_t[i] == 0)) begin
                        m_t[i] = up ? (m_t[i] + 1) % n : (m_t[i] + n - 1) % n;
                        if (m_stop[i] && !up && m_t[i] == 0) m_done[i] = 1;
                        if (al_en && hits_alarm(m_t[i])) m_alarm[i] = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [30:0] model_vec(input int i);
        int h, m, s;
        logic th, tm, ts;
        h = m_t[i] / 3600;
        m = (m_t[i] / 60) % 60;
        s = m_t[i] % 60;
        th = ce && (up ? (h == m_hmax[i]) : (h == 0));
        tm = ce && (up ? (m == 59) : (m == 0));
        ts = ce && (up ? (s == 59) : (s == 0));
        return {to_bcd(h), to_bcd(m), to_bcd(s), th, tm, ts,
                m_tick[i], m_done[i], m_alarm[i], m_lderr[i]};
    endfunction

    function automatic logic [30:0] dut_vec(input int i);
        return {q_h[i], q_m[i], q_s[i], tc_h[i], tc_m[i], tc_s[i],
                tick[i], done[i], alarm[i], ld_err[i]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare every instance.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model dut%0d {q,tc,tick,done,alarm,lderr}", i),
                  64'(dut_vec(i)), 64'(model_vec(i)));
        end
    endtask

    task automatic drive(input logic c_r, input logic p_e, input logic c_e, input logic u_p,
                         input logic [7:0] dh, input logic [7:0] dm, input logic [7:0] ds);
        cr = c_r; pe = p_e; ce = c_e; up = u_p; d_h = dh; d_m = dm; d_s = ds;
    endtask

    typedef struct {
        logic        cr, pe, ce, up;
        logic [7:0]  dh, dm, ds;
        logic [23:0] q;
        logic [2:0]  tc;    // {TC_H, TC_M, TC_S}
        logic        done, lderr;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input logic c_r, input logic p_e, input logic c_e, input logic u_p,
                           input logic [7:0] dh, input logic [7:0] dm, input logic [7:0] ds,
                           input logic [23:0] q, input logic [2:0] tc,
                           input logic dn, input logic le);
        vec_t v;
        v.cr = c_r; v.pe = p_e; v.ce = c_e; v.up = u_p;
        v.dh = dh; v.dm = dm; v.ds = ds;
        v.q = q; v.tc = tc; v.done = dn; v.lderr = le;
        tbl.push_back(v);
    endtask

    int first, nt, na;

    initial begin
        // Vector table for instance A (DIV=1, hours 00..23, stop at zero).
        add_row(1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 24'h000000, 3'b000, 0, 0);
        add_row(0, 1, 1, 1, 8'h23, 8'h59, 8'h58, 24'h235958, 3'b110, 0, 0);
        add_row(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 24'h235959, 3'b111, 0, 0);
        add_row(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 24'h000000, 3'b000, 0, 0);
        add_row(0, 1, 0, 1, 8'h12, 8'h60, 8'h5A, 24'h120000, 3'b000, 0, 1);
        add_row(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 24'h120000, 3'b000, 0, 0);
        add_row(1, 1, 1, 1, 8'h10, 8'h10, 8'h10, 24'h000000, 3'b000, 0, 0);
        add_row(0, 1, 1, 0, 8'h00, 8'h00, 8'h01, 24'h000001, 3'b110, 0, 0);
        add_row(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 24'h000000, 3'b111, 1, 0);
        add_row(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 24'h000000, 3'b111, 1, 0);
        add_row(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 24'h000001, 3'b000, 0, 0);

        #2;
        foreach (tbl[k]) begin
            drive(tbl[k].cr, tbl[k].pe, tbl[k].ce, tbl[k].up, tbl[k].dh, tbl[k].dm, tbl[k].ds);
            step();
            check($sformatf("table row %0d q", k), 64'({q_h[0], q_m[0], q_s[0]}),
                  64'(tbl[k].q));
            check($sformatf("table row %0d tc/done/lderr", k),
                  64'({tc_h[0], tc_m[0], tc_s[0], done[0], ld_err[0]}),
                  64'({tbl[k].tc, tbl[k].done, tbl[k].lderr}));
        end

        // Prescaler and freeze on instance B (DIV=4).
        drive(0, 1, 1, 1, 8'h00, 8'h00, 8'h00);
        step();
        drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        first = 0; nt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick[1]) begin
                nt++;
                if (first == 0) first = k;
            end
        end
        check("div4 first tick cycle", 64'(first), 64'd4);
        check("div4 tick count", 64'(nt), 64'd3);
        check("div4 q_s", 64'(q_s[1]), 64'h03);
        step(); step();
        ce = 1'b0; nt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick[1]) nt++;
        end
        check("freeze tick count", 64'(nt), 64'd0);
        check("freeze q_s", 64'(q_s[1]), 64'h03);
        ce = 1'b1; first = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (tick[1] && first == 0) first = k;
        end
        check("resume tick cycle", 64'(first), 64'd2);
        check("resume q_s", 64'(q_s[1]), 64'h04);

        // Countdown to zero with stop on instance A.
        drive(0, 1, 1, 0, 8'h00, 8'h01, 8'h01);
        step();
        drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        step();
        check("down first step", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000100);
        repeat (60) step();
        check("down reached zero q", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000000);
        check("down reached zero done", 64'(done[0]), 64'd1);
        repeat (5) step();
        check("down held q", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000000);
        check("down held done", 64'(done[0]), 64'd1);
        drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h05);
        step();
        check("load clears done", 64'(done[0]), 64'd0);
        check("load after done q", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000005);

        // Countdown wrap on instance C (hours 00..11, no stop).
        drive(0, 1, 1, 0, 8'h00, 8'h00, 8'h00);
        step();
        drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        step();
        check("wrap q", 64'({q_h[2], q_m[2], q_s[2]}), 64'h115959);
        check("wrap done", 64'(done[2]), 64'd0);
        check("loaded zero parked q", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000000);
        check("loaded zero no done", 64'(done[0]), 64'd0);

        // Alarm on instance A.
        al_en = 1'b1; al_h = 8'h00; al_m = 8'h01; al_s = 8'h00;
        drive(0, 1, 1, 1, 8'h00, 8'h00, 8'h58);
        step();
        drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        na = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (alarm[0]) begin
                na++;
                check("alarm q", 64'({q_h[0], q_m[0], q_s[0]}), 64'h000100);
            end
        end
        check("alarm pulse count", 64'(na), 64'd1);
        drive(0, 1, 0, 1, 8'h00, 8'h01, 8'h00);
        na = 0;
        step();
        if (alarm[0]) na++;
        drive(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step();
            if (alarm[0]) na++;
        end
        check("load match no alarm", 64'(na), 64'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cr = ($urandom_range(0, 199) == 0);
            pe = ($urandom_range(0, 29) == 0);
            ce = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) up = ~up;
            d_h = ($urandom_range(0, 1) == 0) ? 8'h00 :
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : to_bcd($urandom_range(0, 23));
            d_m = ($urandom_range(0, 1) == 0) ? 8'h00 :
                  ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                              : to_bcd($urandom_range(0, 59));
            d_s = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                              : to_bcd($urandom_range(0, 59));
            if ($urandom_range(0, 49) == 0) begin
                al_en = ($urandom_range(0, 3) != 0);
                al_h  = 8'h00;
                al_m  = to_bcd($urandom_range(0, 1));
                al_s  = to_bcd($urandom_range(0, 59));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
